// File: rtl/jfpjc_pkg.sv
// Shared types and constants for the jfpjc output path.
// The framer state encoding lives here so other blocks can decode busy/phase.
package jfpjc_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StHeader,
      StData,
      StEoiFf,
      StEoiD9
   } framer_state_e;

   localparam logic [7:0] JPEG_EOI_HI = 8'hFF;
   localparam logic [7:0] JPEG_EOI_LO = 8'hD9;

   localparam int unsigned HEADER_LEN_DEFAULT = 328;

   // Compressor bytes are only buffered while a frame body can still grow.
   function automatic logic accepts_input(framer_state_e s);
      return (s == StHeader) || (s == StData);
   endfunction

endpackage

// File: rtl/jfpjc_byte_fifo.sv
// Synchronous byte FIFO with first-word-fall-through read data.
// A read and a write in the same cycle is legal even when full.
module jfpjc_byte_fifo #(
   parameter int unsigned DEPTH = 16,
   localparam int unsigned PTR_W = $clog2(DEPTH)
) (
   input  logic             i_clock,
   input  logic             i_nreset,
   input  logic             i_clear,
   input  logic             i_wr,
   input  logic [7:0]       i_wdata,
   input  logic             i_rd,
   output logic [7:0]       o_rdata,
   output logic             o_full,
   output logic             o_empty,
   output logic [PTR_W:0]   o_count
);

   logic [7:0]   r_mem [DEPTH];
   logic [PTR_W:0] r_wptr;
   logic [PTR_W:0] r_rptr;
   logic         w_do_rd;
   logic         w_do_wr;

   always_comb begin
      o_empty = (r_wptr == r_rptr);
      o_full  = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);
      o_count = r_wptr - r_rptr;
      o_rdata = r_mem[r_rptr[PTR_W-1:0]];
      w_do_rd = i_rd && !o_empty;
      w_do_wr = i_wr && (!o_full || w_do_rd);
   end

   always_ff @(posedge i_clock or negedge i_nreset) begin
      if (!i_nreset) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else if (i_clear) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_do_wr) r_wptr <= r_wptr + 1'b1;
         if (w_do_rd) r_rptr <= r_rptr + 1'b1;
      end
   end

   always_ff @(posedge i_clock) begin
      if (w_do_wr && !i_clear) r_mem[r_wptr[PTR_W-1:0]] <= i_wdata;
   end

endmodule

// File: rtl/jfpjc_output_framer.sv
// Wraps the jfpjc entropy-coded byte stream into a JPEG file: EBR header, FIFO'd body, FF D9.
// Output is a registered byte with a valid/ready handshake.
module jfpjc_output_framer
   import jfpjc_pkg::*;
#(
   parameter int unsigned HEADER_LEN    = HEADER_LEN_DEFAULT,
   parameter int unsigned HEADER_ADDR_W = 9,
   parameter int unsigned FIFO_DEPTH    = 16
) (
   input  logic                     i_clock,
   input  logic                     i_nreset,
   input  logic                     i_frame_start,
   input  logic                     i_frame_end,
   input  logic                     i_in_valid,
   input  logic [7:0]               i_in_data,
   output logic [HEADER_ADDR_W-1:0] o_header_ebr_raddr,
   output logic                     o_header_ebr_ren,
   output logic                     o_header_ebr_rclk,
   input  logic [7:0]               i_header_ebr_dout,
   output logic                     o_out_valid,
   output logic [7:0]               o_out_data,
   input  logic                     i_out_ready,
   output logic                     o_busy,
   output logic                     o_overflow
);

   localparam logic [HEADER_ADDR_W-1:0] HDR_END = HEADER_ADDR_W'(HEADER_LEN);
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

   framer_state_e            r_state;
   logic [HEADER_ADDR_W-1:0] r_raddr;    // next header address to fetch
   logic [HEADER_ADDR_W-1:0] r_hdr_cnt;  // header bytes moved into the output register
   logic                     r_hdr_dv;   // EBR output holds a fetched, not yet forwarded byte
   logic                     r_end_pend;
   logic                     r_overflow;
   logic                     r_out_valid;
   logic [7:0]               r_out_data;

   logic             w_out_free;
   logic             w_hdr_done;
   logic             w_tail;
   logic             w_ren;
   logic             w_load_hdr;
   logic             w_load_fifo;
   logic             w_start_eoi;
   logic             w_wr;
   logic             w_rd;
   logic             w_drop;
   logic             w_clear;
   logic             w_fifo_full;
   logic             w_fifo_empty;
   logic [7:0]       w_fifo_rdata;
   logic [CNT_W-1:0] w_fifo_count;

   always_comb begin
      w_out_free  = !r_out_valid || i_out_ready;
      w_hdr_done  = (r_hdr_cnt == HDR_END);
      // Body bytes may follow once the last header byte sits in (or left) the output register.
      w_tail      = (r_state == StData) || ((r_state == StHeader) && w_hdr_done);
      w_ren       = (r_state == StHeader) && (r_raddr != HDR_END) && (!r_hdr_dv || w_out_free);
      w_load_hdr  = (r_state == StHeader) && r_hdr_dv && w_out_free;
      w_wr        = i_in_valid && accepts_input(r_state);
      w_load_fifo = w_tail && w_out_free && !w_fifo_empty;
      w_start_eoi = w_tail && w_out_free && r_end_pend && (w_fifo_count == '0) && !w_wr;
      w_rd        = w_load_fifo;
      w_drop      = (w_wr && w_fifo_full && !w_rd) ||
                    (i_in_valid && ((r_state == StEoiFf) || (r_state == StEoiD9)));
      w_clear     = (r_state == StIdle) && i_frame_start;
   end

   jfpjc_byte_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clock  (i_clock),
      .i_nreset (i_nreset),
      .i_clear  (w_clear),
      .i_wr     (w_wr),
      .i_wdata  (i_in_data),
      .i_rd     (w_rd),
      .o_rdata  (w_fifo_rdata),
      .o_full   (w_fifo_full),
      .o_empty  (w_fifo_empty),
      .o_count  (w_fifo_count)
   );

   always_ff @(posedge i_clock or negedge i_nreset) begin
      if (!i_nreset) begin
         r_state     <= StIdle;
         r_raddr     <= '0;
         r_hdr_cnt   <= '0;
         r_hdr_dv    <= 1'b0;
         r_end_pend  <= 1'b0;
         r_overflow  <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else begin
         if (w_drop) r_overflow <= 1'b1;

         case (r_state)
            StIdle: begin
               if (i_frame_start) begin
                  r_state    <= StHeader;
                  r_raddr    <= '0;
                  r_hdr_cnt  <= '0;
                  r_hdr_dv   <= 1'b0;
                  r_end_pend <= 1'b0;
                  r_overflow <= 1'b0;
               end
            end

            StHeader: begin
               if (i_frame_end) r_end_pend <= 1'b1;
               if (w_ren) begin
                  r_raddr  <= r_raddr + 1'b1;
                  r_hdr_dv <= 1'b1;
               end else if (w_load_hdr) begin
                  r_hdr_dv <= 1'b0;
               end

               if (w_load_hdr) begin
                  r_out_data  <= i_header_ebr_dout;
                  r_out_valid <= 1'b1;
                  r_hdr_cnt   <= r_hdr_cnt + 1'b1;
               end else if (w_load_fifo) begin
                  r_out_data  <= w_fifo_rdata;
                  r_out_valid <= 1'b1;
                  r_state     <= StData;
               end else if (w_start_eoi) begin
                  r_out_data  <= JPEG_EOI_HI;
                  r_out_valid <= 1'b1;
                  r_state     <= StEoiFf;
               end else if (w_tail && w_out_free) begin
                  r_out_valid <= 1'b0;
                  r_state     <= StData;
               end else if (i_out_ready) begin
                  r_out_valid <= 1'b0;
               end
            end

            StData: begin
               if (i_frame_end) r_end_pend <= 1'b1;
               if (w_load_fifo) begin
                  r_out_data  <= w_fifo_rdata;
                  r_out_valid <= 1'b1;
               end else if (w_start_eoi) begin
                  r_out_data  <= JPEG_EOI_HI;
                  r_out_valid <= 1'b1;
                  r_state     <= StEoiFf;
               end else if (i_out_ready) begin
                  r_out_valid <= 1'b0;
               end
            end

            StEoiFf: begin
               if (i_out_ready) begin
                  r_out_data <= JPEG_EOI_LO;
                  r_state    <= StEoiD9;
               end
            end

            StEoiD9: begin
               if (i_out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= StIdle;
               end
            end

            default: r_state <= StIdle;
         endcase
      end
   end

   assign o_header_ebr_raddr = r_raddr;
   assign o_header_ebr_ren   = w_ren;
   assign o_header_ebr_rclk  = i_clock;
   assign o_out_valid        = r_out_valid;
   assign o_out_data         = r_out_data;
   assign o_busy             = (r_state != StIdle);
   assign o_overflow         = r_overflow;

   a_stall_stable: assert property (@(posedge i_clock) disable iff (!i_nreset)
      (r_out_valid && !i_out_ready) |=> (r_out_valid && $stable(r_out_data)));

   a_hdr_bound: assert property (@(posedge i_clock) disable iff (!i_nreset)
      (r_hdr_cnt <= HDR_END) && (r_raddr <= HDR_END));

   a_ren_in_range: assert property (@(posedge i_clock) disable iff (!i_nreset)
      w_ren |-> (r_raddr < HDR_END));

endmodule

// File: tb/tb_jfpjc_output_framer.sv
// Directed bench for jfpjc_output_framer: header timing/order, body + EOI, stalls,
// overflow, end-of-frame edge cases and mid-frame reset.
module tb_jfpjc_output_framer;

   logic       clk = 1'b0;
   logic       nreset = 1'b0;
   logic       frame_start = 1'b0;
   logic       frame_end = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic [8:0] raddr;
   logic       ren;
   logic       rclk;
   logic [7:0] ebr_dout = 8'h00;
   logic       out_valid;
   logic [7:0] out_data;
   logic       out_ready = 1'b1;
   logic       busy;
   logic       overflow;

   int         total = 0;
   int         bad = 0;
   int         cyc = 0;
   bit         rdy_pat = 1'b0;
   logic [7:0] acc_q [$];
   int         stall_bad = 0;
   logic       prev_stall = 1'b0;
   logic [7:0] prev_data = 8'h00;
   logic [7:0] ebr_mem [512];

   always #5 clk = ~clk;

   jfpjc_output_framer dut (
      .i_clock            (clk),
      .i_nreset           (nreset),
      .i_frame_start      (frame_start),
      .i_frame_end        (frame_end),
      .i_in_valid         (in_valid),
      .i_in_data          (in_data),
      .o_header_ebr_raddr (raddr),
      .o_header_ebr_ren   (ren),
      .o_header_ebr_rclk  (rclk),
      .i_header_ebr_dout  (ebr_dout),
      .o_out_valid        (out_valid),
      .o_out_data         (out_data),
      .i_out_ready        (out_ready),
      .o_busy             (busy),
      .o_overflow         (overflow)
   );

   initial for (int i = 0; i < 512; i++) ebr_mem[i] = 8'(i);

   // EBR model: registered read, output held while ren is low
   always @(posedge rclk) if (ren) ebr_dout <= ebr_mem[raddr];

   // Output monitor: collects accepted bytes and watches stall stability
   always @(negedge clk) begin
      if (nreset) begin
         if (prev_stall && (!out_valid || out_data !== prev_data)) stall_bad <= stall_bad + 1;
         prev_stall <= out_valid && !out_ready;
         prev_data  <= out_data;
         if (out_valid && out_ready) acc_q.push_back(out_data);
      end else begin
         prev_stall <= 1'b0;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (rdy_pat) out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
   endtask

   task automatic pulse_start();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
   endtask

   task automatic pulse_end();
      frame_end = 1'b1;
      tick();
      frame_end = 1'b0;
   endtask

   task automatic wait_bytes(input int n, input int max_cyc, input string tag);
      int c = 0;
      while (acc_q.size() < n && c < max_cyc) begin
         tick();
         c++;
      end
      check(tag, acc_q.size() >= n, 1);
   endtask

   task automatic wait_idle(input int max_cyc, input string tag);
      int c = 0;
      while (busy && c < max_cyc) begin
         tick();
         c++;
      end
      check(tag, busy, 0);
   endtask

   function automatic int hdr_errs();
      int n = 0;
      for (int i = 0; i < 328 && i < acc_q.size(); i++) if (acc_q[i] !== 8'(i)) n++;
      return n;
   endfunction

   initial begin
      logic [7:0] exp2 [6];
      int nbad;
      int c;
      exp2[0] = 8'h12; exp2[1] = 8'h34; exp2[2] = 8'hFF;
      exp2[3] = 8'h00; exp2[4] = 8'hFF; exp2[5] = 8'hD9;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", out_valid, 0);
      check("rst_data", out_data, 0);
      check("rst_raddr", raddr, 0);
      check("rst_ren", ren, 0);
      check("rst_busy", busy, 0);
      check("rst_ovf", overflow, 0);
      nreset = 1'b1;
      tick();

      // 1: header latency and order at full throughput
      pulse_start();
      check("t1_valid_c0", out_valid, 0);
      check("t1_busy", busy, 1);
      tick();
      check("t1_valid_c1", out_valid, 0);
      tick();
      check("t1_valid_c2", out_valid, 1);
      nbad = 0;
      for (int i = 0; i < 328; i++) begin
         if (!out_valid || out_data !== 8'(i)) nbad++;
         tick();
      end
      check("t1_hdr_seq", nbad, 0);
      check("t1_after_hdr_valid", out_valid, 0);

      // 2: body bytes then frame_end -> FF D9, busy drops after D9 accept
      acc_q.delete();
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_data  = exp2[i];
         tick();
      end
      in_valid = 1'b0;
      pulse_end();
      c = 0;
      while (!(out_valid && out_data == 8'hD9) && c < 50) begin
         tick();
         c++;
      end
      check("t2_d9_seen", out_data, 8'hD9);
      check("t2_busy_at_d9", busy, 1);
      tick();
      check("t2_busy_after_d9", busy, 0);
      check("t2_count", acc_q.size(), 6);
      nbad = 0;
      for (int i = 0; i < 6 && i < acc_q.size(); i++) if (acc_q[i] !== exp2[i]) nbad++;
      check("t2_bytes", nbad, 0);

      // 3: out_ready pattern 1,0,0,1 through the header
      acc_q.delete();
      rdy_pat = 1'b1;
      pulse_start();
      wait_bytes(328, 3000, "t3_wait_hdr");
      pulse_end();
      wait_idle(200, "t3_wait_idle");
      rdy_pat = 1'b0;
      out_ready = 1'b1;
      tick();
      check("t3_count", acc_q.size(), 330);
      check("t3_hdr_errs", hdr_errs(), 0);
      check("t3_eoi_hi", acc_q[328], 8'hFF);
      check("t3_eoi_lo", acc_q[329], 8'hD9);
      check("t3_stall_stable", stall_bad, 0);

      // 4: stalled header with 17 body bytes -> one drop, overflow set
      acc_q.delete();
      out_ready = 1'b0;
      pulse_start();
      for (int i = 0; i < 17; i++) begin
         in_valid = 1'b1;
         in_data  = 8'h80 + 8'(i);
         tick();
      end
      in_valid = 1'b0;
      check("t4_ovf_set", overflow, 1);
      pulse_end();
      out_ready = 1'b1;
      wait_idle(1000, "t4_wait_idle");
      tick();
      check("t4_count", acc_q.size(), 346);
      check("t4_hdr_errs", hdr_errs(), 0);
      nbad = 0;
      for (int i = 0; i < 16 && (328 + i) < acc_q.size(); i++)
         if (acc_q[328 + i] !== 8'h80 + 8'(i)) nbad++;
      check("t4_body", nbad, 0);
      check("t4_eoi_hi", acc_q[344], 8'hFF);
      check("t4_eoi_lo", acc_q[345], 8'hD9);
      check("t4_ovf_sticky", overflow, 1);

      // 5: frame_start clears overflow; frame_end with a same-cycle byte; start during EOI
      acc_q.delete();
      pulse_start();
      check("t5_ovf_cleared", overflow, 0);
      wait_bytes(328, 1000, "t5_wait_hdr");
      tick();
      tick();
      in_valid   = 1'b1;
      in_data    = 8'hAB;
      frame_end  = 1'b1;
      tick();
      in_valid   = 1'b0;
      frame_end  = 1'b0;
      c = 0;
      while (!(out_valid && out_data == 8'hFF) && c < 50) begin
         tick();
         c++;
      end
      check("t5_ff_seen", out_data, 8'hFF);
      pulse_start();
      wait_idle(50, "t5_wait_idle");
      repeat (10) tick();
      check("t5_no_restart", busy, 0);
      check("t5_count", acc_q.size(), 331);
      check("t5_ab", acc_q[328], 8'hAB);
      check("t5_eoi_hi", acc_q[329], 8'hFF);
      check("t5_eoi_lo", acc_q[330], 8'hD9);
      check("t5_ovf", overflow, 0);

      // 6: reset at header byte 100, then a clean restart
      acc_q.delete();
      pulse_start();
      c = 0;
      while (!(out_valid && out_data == 8'h64) && c < 500) begin
         tick();
         c++;
      end
      check("t6_byte100", out_data, 8'h64);
      #2;
      nreset = 1'b0;
      #1;
      check("t6_rst_valid", out_valid, 0);
      check("t6_rst_data", out_data, 0);
      check("t6_rst_raddr", raddr, 0);
      check("t6_rst_ren", ren, 0);
      check("t6_rst_busy", busy, 0);
      @(posedge clk);
      #1;
      nreset = 1'b1;
      tick();
      acc_q.delete();
      pulse_start();
      tick();
      tick();
      check("t6_restart_valid", out_valid, 1);
      check("t6_restart_data", out_data, 8'h00);
      check("t6_restart_raddr", raddr, 2);
      wait_bytes(328, 1000, "t6_wait_hdr");
      pulse_end();
      wait_idle(50, "t6_wait_idle");
      tick();
      check("t6_count", acc_q.size(), 330);
      check("t6_hdr_errs", hdr_errs(), 0);
      check("stall_stable_all", stall_bad, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule

// File: doc/jfpjc_output_framer.md
Name: jfpjc_output_framer

Overview:
Sits directly downstream of jfpjc and consumes its entropy-coded byte stream (hsync/data_out). It wraps each frame into a complete JPEG file stream: the fixed header is read from a header EBR, compressed bytes are buffered through a small FIFO, and FF D9 (EOI) is appended at frame end. Output is a byte stream with a valid/ready handshake toward the host link (SPI/UART bridge).

Parameters:
HEADER_LEN, 328, number of header bytes emitted from the EBR, addresses 0..HEADER_LEN-1.
HEADER_ADDR_W, 9, header EBR address width.
FIFO_DEPTH, 16, compressed-byte FIFO depth; must be a power of 2.

Ports:
clock  in  1  system clock
nreset  in  1  asynchronous active-low reset
frame_start  in  1  one-cycle pulse, clock domain; starts a frame
frame_end  in  1  one-cycle pulse; the last compressor byte has arrived (same cycle or earlier)
in_valid  in  1  compressor byte strobe (jfpjc hsync)
in_data  in  8  compressor byte (jfpjc data_out)
header_ebr_raddr  out  HEADER_ADDR_W  header EBR read address
header_ebr_ren  out  1  header EBR read enable
header_ebr_rclk  out  1  header EBR read clock, = clock
header_ebr_dout  in  8  header EBR data, valid 1 cycle after a ren edge; held while ren=0
out_valid  out  1  output byte valid
out_data  out  8  output byte
out_ready  in  1  downstream accepts when out_valid&&out_ready
busy  out  1  high in any state other than IDLE
overflow  out  1  sticky: a compressor byte was dropped

Behaviour:
- Reset (async, nreset=0): state IDLE; out_valid=0, out_data=0, header_ebr_raddr=0, header_ebr_ren=0, busy=0, overflow=0; FIFO empty; pending-end flag cleared. Reset mid-frame abandons the frame with no EOI.
- States:
  - IDLE
  - HEADER: emit HEADER_LEN bytes from the EBR.
  - DATA: drain the FIFO to the output.
  - EOI_FF
  - EOI_D9
- IDLE -> HEADER on frame_start. This clears overflow, resets raddr to 0, and clears the FIFO.
  - frame_start in any other state is ignored.
  - in_valid in IDLE: byte dropped; overflow is not set.
- HEADER:
  - Header byte n is addr n. Emission is strictly in order, one per cycle while out_ready=1.
  - First header byte: out_valid=1 at cycle 2 after the frame_start cycle.
  - ren is asserted only when the fetched byte can enter the output register; the EBR output is held across stalls.
  - After byte HEADER_LEN-1 is accepted -> DATA.
- Output register:
  - out_data/out_valid are registered.
  - While out_valid=1 and out_ready=0, out_data is stable.
  - Full throughput is 1 byte/cycle with no bubbles between phases when out_ready=1.
- FIFO:
  - Accepts in_valid bytes in HEADER, DATA and EOI-pending.
  - Write when full: byte dropped, overflow<=1.
  - Simultaneous read and write while full is a legal write, with no drop.
  - Bytes leave in arrival order.
- frame_end:
  - Sets pending-end in HEADER or DATA.
  - A same-cycle in_valid byte is included before EOI.
  - A second frame_end is ignored.
- DATA -> EOI_FF when pending-end=1, FIFO empty, and no write in the current cycle.
  - EOI_FF emits 0xFF; on accept -> EOI_D9.
  - EOI_D9 emits 0xD9; on accept -> IDLE.
- in_valid during EOI_FF/EOI_D9: dropped, overflow<=1.
- No byte stuffing here; jfpjc already stuffs 0x00 after 0xFF.
- Pointers: log2(FIFO_DEPTH)+1 bits with wrap.
- Header counter: HEADER_ADDR_W bits, no wrap; saturates at HEADER_LEN.

Decomposition:
- Shared package jfpjc_pkg holds:
  - state enum (IDLE, HEADER, DATA, EOI_FF, EOI_D9);
  - constants JPEG_EOI_HI=8'hFF, JPEG_EOI_LO=8'hD9;
  - default HEADER_LEN=328.
- One sub-module: jfpjc_byte_fifo (sync FIFO, width 8, depth FIFO_DEPTH, full/empty, count), reusable elsewhere in the datapath.

Test Plan:
1. Header EBR preloaded with addr[7:0], out_ready=1, pulse frame_start -> out_valid high at cycle 2, then 328 consecutive bytes 00,01,..,FF,00,..,47.
2. After the header, inject bytes 12,34,FF,00 then frame_end -> output 12,34,FF,00,FF,D9; busy falls the cycle after D9 is accepted.
3. out_ready toggled 1,0,0,1 repeatedly through the header -> no byte lost or duplicated; out_data stable during each stall; count still 328.
4. out_ready=0 during the header, 17 in_valid bytes -> overflow=1; after ready returns, exactly the first 16 bytes follow the header; next frame_start clears overflow.
5. frame_end on the same cycle as in_valid=AB while the FIFO is empty in DATA -> AB precedes FF D9; a frame_start during EOI is ignored (no second header).
6. nreset asserted at header byte 100 -> all outputs 0 immediately; the next frame_start restarts the header at addr 0.
